// File: rtl/move_cmd_exec_pkg.sv
// move_cmd_exec_pkg: opcodes and compass headings shared by the command producers and the executor
package move_cmd_exec_pkg;
    typedef enum logic [3:0] {OP_CAL = 4'h0, OP_MOVE = 4'h2, OP_MOVE_FF = 4'h3} opcode_t;
    localparam logic [7:0] HDG_N = 8'h00, HDG_W = 8'h3F, HDG_S = 8'h7F, HDG_E = 8'hBF;
    function automatic logic [11:0] hdg_expand(input logic [7:0] h);
        return (h == 8'h00) ? 12'h000 : {h, 4'hF};
    endfunction
endpackage

// File: rtl/move_cmd_exec_line_counter.sv
// move_cmd_exec_line_counter: synchronises cntrIR and counts its rising edges, with clear
module move_cmd_exec_line_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cntrIR,
    input  logic       clr,
    output logic [4:0] lines
);
    logic [2:0] sync;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync  <= '0;
            lines <= '0;
        end else begin
            sync  <= {sync[1:0], cntrIR};
            lines <= clr ? 5'd0 : lines + 5'(sync[1] & ~sync[2]);
        end
endmodule

// File: rtl/move_cmd_exec.sv
// move_cmd_exec: takes one command from the command mux and runs calibrate or turn-then-drive
module move_cmd_exec
    import move_cmd_exec_pkg::*;
#(
    parameter logic       FAST_SIM   = 1'b1,
    parameter logic [9:0] MAX_SPD    = 10'h2A0,
    parameter logic [11:0] HDG_THRESH = 12'd30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    output logic        send_resp,
    output logic        strt_cal,
    input  logic        cal_done,
    input  logic        heading_rdy,
    input  logic [11:0] error,
    input  logic        cntrIR,
    output logic [11:0] dsrd_hdg,
    output logic [9:0]  frwrd,
    output logic        moving,
    output logic        fanfare_go
);
    typedef enum logic [2:0] {IDLE, CAL, HDG, RAMP, DECEL, DONE} state_t;
    localparam logic [9:0] STEP  = FAST_SIM ? 10'h020 : 10'h003;
    localparam logic [9:0] STEP2 = {STEP[8:0], 1'b0};
    state_t      state, nxt;
    logic [3:0]  op, squares;
    logic [4:0]  lines;
    logic [12:0] err_abs;
    logic [10:0] up;
    logic        is_move, settled, clr_lines;
    assign is_move = (cmd[15:12] == OP_MOVE) || (cmd[15:12] == OP_MOVE_FF);
    // widened to 13 bits so that -2048 has a representable magnitude
    assign err_abs = error[11] ? -{1'b1, error} : {1'b0, error};
    assign settled = err_abs < {1'b0, HDG_THRESH};
    assign up      = {1'b0, frwrd} + {1'b0, STEP};
    move_cmd_exec_line_counter u_lines (
        .clk    (clk),
        .rst_n  (rst_n),
        .cntrIR (cntrIR),
        .clr    (clr_lines),
        .lines  (lines)
    );
    always_comb begin
        nxt         = state;
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        fanfare_go  = 1'b0;
        moving      = 1'b0;
        clr_lines   = 1'b0;
        case (state)
            IDLE: if (cmd_rdy && rst_n) begin
                clr_cmd_rdy = 1'b1;
                nxt = (cmd[15:12] == OP_CAL) ? CAL : is_move ? HDG : IDLE;
            end
            CAL: if (cal_done) begin
                send_resp = 1'b1;
                nxt = IDLE;
            end
            HDG: begin
                moving = 1'b1;
                if (heading_rdy && settled) begin
                    clr_lines = 1'b1;
                    nxt = (squares == 4'd0) ? DONE : RAMP;
                end
            end
            RAMP: begin
                moving = 1'b1;
                nxt = (lines == {squares, 1'b0}) ? DECEL : RAMP;
            end
            DECEL: begin
                moving = 1'b1;
                nxt = (frwrd == 10'h000) ? DONE : DECEL;
            end
            DONE: begin
                send_resp  = 1'b1;
                fanfare_go = (op == OP_MOVE_FF);
                nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= IDLE;
            op       <= 4'h0;
            squares  <= 4'h0;
            dsrd_hdg <= 12'h000;
            frwrd    <= 10'h000;
            strt_cal <= 1'b0;
        end else begin
            state    <= nxt;
            strt_cal <= clr_cmd_rdy && (cmd[15:12] == OP_CAL);
            if (clr_cmd_rdy) begin
                op      <= cmd[15:12];
                squares <= cmd[3:0];
            end
            if (clr_cmd_rdy && is_move)
                dsrd_hdg <= hdg_expand(cmd[11:4]);
            if (heading_rdy && state == RAMP)
                frwrd <= (up > {1'b0, MAX_SPD}) ? MAX_SPD : up[9:0];
            else if (heading_rdy && state == DECEL)
                frwrd <= (frwrd > STEP2) ? frwrd - STEP2 : 10'h000;
        end
endmodule

// File: tb/tb_move_cmd_exec.sv
// tb_move_cmd_exec: scoreboard bench for move_cmd_exec with a queue-based event model
module tb_move_cmd_exec;
    import move_cmd_exec_pkg::*;
    localparam int STEP = 32;
    localparam int MAX  = 'h2A0;
    logic        clk = 0, rst_n = 0, cmd_rdy = 0, cal_done = 0, heading_rdy = 0, cntrIR = 0;
    logic [15:0] cmd = 0;
    logic [11:0] error = 0;
    logic        clr_cmd_rdy, send_resp, strt_cal, moving, fanfare_go;
    logic [11:0] dsrd_hdg;
    logic [9:0]  frwrd;
    int          total = 0, bad = 0, exp_frwrd = 0;
    logic [11:0] exp_hdg = 0;
    typedef struct {int kind; logic [11:0] hdg; logic ff;} ev_t;
    ev_t q[$];

    always #5 clk = ~clk;

    move_cmd_exec dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .send_resp(send_resp), .strt_cal(strt_cal), .cal_done(cal_done), .heading_rdy(heading_rdy),
        .error(error), .cntrIR(cntrIR), .dsrd_hdg(dsrd_hdg), .frwrd(frwrd), .moving(moving),
        .fanfare_go(fanfare_go)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // kinds: 0 ack, 1 strt_cal, 2 response
    task automatic take_ev(input int kind);
        ev_t e;
        if (q.size() == 0) check("unexpected_event", kind, -1);
        else begin
            e = q.pop_front();
            check("event_kind", kind, e.kind);
            if (kind == 2) begin
                check("resp_fanfare", int'(fanfare_go), int'(e.ff));
                check("resp_dsrd_hdg", int'(dsrd_hdg), int'(e.hdg));
            end
        end
    endtask

    always @(negedge clk) begin
        check("frwrd", int'(frwrd), exp_frwrd);
        check("ack_resp_overlap", int'(clr_cmd_rdy & send_resp), 0);
        check("fanfare_alone", int'(fanfare_go & ~send_resp), 0);
        if (clr_cmd_rdy) take_ev(0);
        if (strt_cal) take_ev(1);
        if (send_resp) take_ev(2);
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [11:0] h, input logic ff);
        ev_t e;
        e.kind = kind; e.hdg = h; e.ff = ff;
        q.push_back(e);
    endtask

    task automatic wait_ack;
        int n = 0;
        @(negedge clk);
        while (!clr_cmd_rdy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("ack_seen", int'(clr_cmd_rdy), 1);
        cyc;
        cmd_rdy = 0;
    endtask

    task automatic expect_cmd(input logic [15:0] c);
        logic [3:0] op;
        op = c[15:12];
        push(0, 0, 0);
        if (op == 4'h0) begin
            push(1, 0, 0);
            push(2, exp_hdg, 0);
        end else if (op == 4'h2 || op == 4'h3) begin
            exp_hdg = (c[11:4] == 0) ? 12'h000 : {c[11:4], 4'hF};
            push(2, exp_hdg, op == 4'h3);
        end
    endtask

    task automatic issue(input logic [15:0] c);
        expect_cmd(c);
        cmd = c;
        cmd_rdy = 1;
        wait_ack;
    endtask

    task automatic drain;
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            cyc;
            n++;
        end
        check("events_left", q.size(), 0);
        q.delete();
    endtask

    // mode 0: heading phase, 1: accelerating, 2: decelerating
    task automatic hpulse(input int mode, input logic [11:0] e);
        error = e;
        heading_rdy = 1;
        cyc;
        heading_rdy = 0;
        if (mode == 1) exp_frwrd = (exp_frwrd + STEP > MAX) ? MAX : exp_frwrd + STEP;
        else if (mode == 2) exp_frwrd = (exp_frwrd > 2 * STEP) ? exp_frwrd - 2 * STEP : 0;
    endtask

    task automatic line_edge(input logic with_hr);
        cntrIR = 1;
        cyc;
        cyc;
        if (with_hr) hpulse(1, 0);
        else cyc;
        cntrIR = 0;
        cyc;
        cyc;
    endtask

    function automatic logic [11:0] big_err();
        int v;
        case ($urandom_range(0, 4))
            0: v = -2048;
            1: v = 2047;
            2: v = 30;
            3: v = -30;
            default: v = $urandom_range(30, 2047) * ($urandom_range(0, 1) ? 1 : -1);
        endcase
        return 12'(v);
    endfunction

    function automatic logic [11:0] small_err();
        return 12'(int'($urandom_range(0, 58)) - 29);
    endfunction

    task automatic drive(input int sq, input int pre);
        if (sq != 0) begin
            repeat (pre) hpulse(1, small_err());
            for (int i = 0; i < 2 * sq; i++) begin
                repeat ($urandom_range(0, 2)) hpulse(1, small_err());
                line_edge(1'($urandom_range(0, 1)));
            end
            repeat (4) cyc;
            while (exp_frwrd != 0) hpulse(2, small_err());
        end
    endtask

    task automatic motion(input int sq, input int pre);
        check("hdg_moving", int'(moving), 1);
        check("hdg_dsrd_hdg", int'(dsrd_hdg), int'(exp_hdg));
        repeat ($urandom_range(0, 3)) hpulse(0, big_err());
        hpulse(0, small_err());
        drive(sq, pre);
    endtask

    initial begin
        logic [15:0] c;
        #2;
        check("rst_clr_cmd_rdy", int'(clr_cmd_rdy), 0);
        check("rst_send_resp", int'(send_resp), 0);
        check("rst_strt_cal", int'(strt_cal), 0);
        check("rst_moving", int'(moving), 0);
        check("rst_dsrd_hdg", int'(dsrd_hdg), 0);
        check("rst_fanfare", int'(fanfare_go), 0);
        cyc;
        rst_n = 1;
        cyc;
        // calibrate
        issue(16'h0000);
        check("strt_cal_after_ack", int'(strt_cal), 1);
        repeat (20) cyc;
        cal_done = 1;
        cyc;
        cal_done = 0;
        drain;
        // two squares north, full ramp to the ceiling
        issue(16'h2002);
        check("hdg_north", int'(dsrd_hdg), 12'h000);
        hpulse(0, 12'd5);
        drive(2, 25);
        drain;
        // east, one square, with fanfare
        issue(16'h3BF1);
        check("hdg_east", int'(dsrd_hdg), 12'hBFF);
        motion(1, 5);
        drain;
        // zero squares, then an unknown opcode
        issue(16'h23F0);
        check("hdg_west", int'(dsrd_hdg), 12'h3FF);
        hpulse(0, 12'd0);
        drain;
        issue(16'h5123);
        repeat (10) cyc;
        drain;
        // heading boundaries, and a command held pending during the move
        issue(16'h27F1);
        repeat (3) hpulse(0, 12'h800);
        hpulse(0, 12'd30);
        check("hdg_hold_moving", int'(moving), 1);
        c = 16'h9ABC;
        expect_cmd(c);
        cmd = c;
        cmd_rdy = 1;
        hpulse(0, 12'(-29));
        drive(1, 3);
        wait_ack;
        drain;
        // asynchronous reset mid-ramp
        issue(16'h2004);
        hpulse(0, 12'd1);
        repeat (8) hpulse(1, 12'd0);
        check("ramp_0x100", int'(frwrd), 'h100);
        rst_n = 0;
        exp_frwrd = 0;
        exp_hdg = 0;
        q.delete();
        #1;
        check("arst_frwrd", int'(frwrd), 0);
        check("arst_moving", int'(moving), 0);
        check("arst_dsrd_hdg", int'(dsrd_hdg), 0);
        cyc;
        rst_n = 1;
        cyc;
        cyc;
        check("post_rst_idle", int'(moving), 0);
        issue(16'h0000);
        repeat ($urandom_range(1, 10)) cyc;
        cal_done = 1;
        cyc;
        cal_done = 0;
        drain;
        // randomized command stream
        for (int n = 0; n < 14; n++) begin
            int kind;
            logic [7:0] h;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                issue(16'(4'h0 << 12) | 16'($urandom_range(0, 'hFFF)));
                repeat ($urandom_range(1, 20)) cyc;
                cal_done = 1;
                cyc;
                cal_done = 0;
            end else if (kind == 1) begin
                c = 16'($urandom_range(0, 'hFFFF));
                if (c[15:12] == 4'h0 || c[15:12] == 4'h2 || c[15:12] == 4'h3) c[15:12] = 4'hF;
                issue(c);
                repeat (4) cyc;
            end else begin
                case ($urandom_range(0, 4))
                    0: h = HDG_N;
                    1: h = HDG_W;
                    2: h = HDG_S;
                    3: h = HDG_E;
                    default: h = 8'($urandom_range(0, 255));
                endcase
                c = {($urandom_range(0, 1) ? 4'h3 : 4'h2), h, 4'($urandom_range(0, 5))};
                issue(c);
                motion(int'(c[3:0]), $urandom_range(0, 25));
            end
            drain;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
